// File: rtl/alu_issue.sv
// alu_issue -- decode/issue stage between instruction decode and the ALU.
//
// Decodes a 16-bit instruction plus its two register-file reads into an ALU
// operation (operands, opcode, funct bits, inversion/carry controls). A
// 2-entry skid buffer (output register + skid register) sits behind the
// decode logic. A small FSM stops intake after a HALT until reset.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   decode-side handshake
//   in_instr            instruction word, opcode in [15:11]
//   in_rs_data          value of Rs
//   in_rt_data          value of Rt
//   flush               drop everything buffered and the current input
//   out_valid/out_ready execute-side handshake
//   out_A, out_B        ALU operands
//   out_opcode          in_instr[15:11]
//   out_twoLSB          in_instr[1:0]
//   out_ctrl            {invA, invB, Cin}
//   out_halt            presented operation is HALT
//   perf_count          hand-off counter, saturating (only with ALU_ISSUE_PERF_EN)
//
// Build option: define ALU_ISSUE_PERF_EN to add the perf_count port/counter.

module alu_issue (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_instr,
   input  logic [15:0] in_rs_data,
   input  logic [15:0] in_rt_data,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_A,
   output logic [15:0] out_B,
   output logic [4:0]  out_opcode,
   output logic [1:0]  out_twoLSB,
   output logic [2:0]  out_ctrl,
   output logic        out_halt
`ifdef ALU_ISSUE_PERF_EN
  ,output logic [15:0] perf_count
`endif
);

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [4:0]  opcode;
      logic [1:0]  two_lsb;
      logic [2:0]  ctrl;
      logic        halt;
   } op_t;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      HALT_PEND = 2'd1,
      HALTED    = 2'd2
   } state_t;

   state_t state_q, state_d;

   op_t  dec;
   op_t  out_q, skid_q;
   logic out_valid_q, skid_valid_q;
   logic accept, handoff;

   // ---------------------------------------------------------------- decode
   logic [4:0]  op;
   logic [15:0] imm5_s, imm5_z, imm8_s, imm8_z, disp11_s;

   assign op       = in_instr[15:11];
   assign imm5_s   = {{11{in_instr[4]}}, in_instr[4:0]};
   assign imm5_z   = {11'd0, in_instr[4:0]};
   assign imm8_s   = {{8{in_instr[7]}}, in_instr[7:0]};
   assign imm8_z   = {8'd0, in_instr[7:0]};
   assign disp11_s = {{5{in_instr[10]}}, in_instr[10:0]};

   always_comb begin
      dec         = '0;
      dec.opcode  = op;
      dec.two_lsb = in_instr[1:0];
      dec.halt    = (op == 5'b00000);
      dec.a       = in_rs_data;

      unique case (op)
         5'b11011, 5'b11010,
         5'b11100, 5'b11101, 5'b11110, 5'b11111:
            dec.b = in_rt_data;
         5'b01000, 5'b01001, 5'b10000, 5'b10001, 5'b10011:
            dec.b = imm5_s;
         5'b01010, 5'b01011,
         5'b10100, 5'b10101, 5'b10110, 5'b10111:
            dec.b = imm5_z;
         5'b01100, 5'b01101, 5'b01110, 5'b01111,
         5'b11000, 5'b00101, 5'b00111:
            dec.b = imm8_s;
         5'b10010:
            dec.b = imm8_z;
         5'b00100, 5'b00110:
            dec.b = disp11_s;
         default:
            dec.b = 16'h0000;
      endcase

      // HALT/NOP/siic/RTI carry no operands
      if (op[4:2] == 3'b000) begin
         dec.a = 16'h0000;
         dec.b = 16'h0000;
      end

      // {invA, invB, Cin}: subtract computes B - A, ANDN inverts B,
      // compares compute A - B
      unique case (op)
         5'b01001: dec.ctrl = 3'b101;
         5'b01011: dec.ctrl = 3'b010;
         5'b11011: begin
            if (in_instr[1:0] == 2'b01)
               dec.ctrl = 3'b101;
            else if (in_instr[1:0] == 2'b11)
               dec.ctrl = 3'b010;
            else
               dec.ctrl = 3'b000;
         end
         5'b11100, 5'b11101, 5'b11110: dec.ctrl = 3'b011;
         default: dec.ctrl = 3'b000;
      endcase
   end

   // ------------------------------------------------------------ handshakes
   // in_ready comes only from flops (plus the reset input), so there is no
   // combinational path from out_ready back to the producer.
   assign in_ready = rst_n && !skid_valid_q && (state_q == RUN);
   assign accept   = in_valid && in_ready;
   assign handoff  = out_valid_q && out_ready;

   // ------------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (!rst_n)
         state_q <= RUN;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN: begin
            if (!flush && accept && dec.halt)
               state_d = HALT_PEND;
         end
         HALT_PEND: begin
            // HALT is the last thing accepted, so handing off any HALT
            // here means the buffer has drained
            if (flush)
               state_d = RUN;
            else if (handoff && out_q.halt)
               state_d = HALTED;
         end
         HALTED: state_d = HALTED;
         default: state_d = RUN;
      endcase
   end

   // ----------------------------------------------------------- skid buffer
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q        <= '0;
         skid_q       <= '0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
      end else if (flush) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
      end else if (!out_valid_q || out_ready) begin
         // output slot frees up this cycle; skid (older) goes first. The
         // skid is never full while accepting, so no refill is needed.
         if (skid_valid_q) begin
            out_q        <= skid_q;
            out_valid_q  <= 1'b1;
            skid_valid_q <= 1'b0;
         end else if (accept) begin
            out_q       <= dec;
            out_valid_q <= 1'b1;
         end else begin
            out_valid_q <= 1'b0;
         end
      end else if (accept) begin
         // output stalled: park the new op in the skid register
         skid_q       <= dec;
         skid_valid_q <= 1'b1;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_A      = out_q.a;
   assign out_B      = out_q.b;
   assign out_opcode = out_q.opcode;
   assign out_twoLSB = out_q.two_lsb;
   assign out_ctrl   = out_q.ctrl;
   assign out_halt   = out_q.halt;

`ifdef ALU_ISSUE_PERF_EN
   // flush wins over a same-cycle hand-off, so that cycle is not counted
   always_ff @(posedge clk) begin
      if (!rst_n)
         perf_count <= 16'h0000;
      else if (handoff && !flush && (perf_count != 16'hFFFF))
         perf_count <= perf_count + 16'h0001;
   end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Testbench for alu_issue: table-driven decode vectors plus directed
// sequences for stall/ordering, HALT/flush, and reset with a full buffer.

module tb_alu_issue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_instr;
   logic [15:0] in_rs_data;
   logic [15:0] in_rt_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_A;
   logic [15:0] out_B;
   logic [4:0]  out_opcode;
   logic [1:0]  out_twoLSB;
   logic [2:0]  out_ctrl;
   logic        out_halt;
`ifdef ALU_ISSUE_PERF_EN
   logic [15:0] perf_count;
`endif

   alu_issue dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .in_rs_data (in_rs_data),
      .in_rt_data (in_rt_data),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_A      (out_A),
      .out_B      (out_B),
      .out_opcode (out_opcode),
      .out_twoLSB (out_twoLSB),
      .out_ctrl   (out_ctrl),
      .out_halt   (out_halt)
`ifdef ALU_ISSUE_PERF_EN
     ,.perf_count (perf_count)
`endif
   );

   always #5 clk = ~clk;

   int total  = 0;
   int passed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp)
         passed++;
      else
         $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   typedef struct {
      logic [15:0] instr;
      logic [15:0] rs;
      logic [15:0] rt;
      logic [15:0] a;
      logic [15:0] b;
      logic [4:0]  op;
      logic [1:0]  lsb;
      logic [2:0]  ctrl;
      logic        halt;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs [NV];

   logic [15:0] vals [3];
   logic [15:0] seen [$];
   logic [15:0] got;
   int          sent;

   task automatic all_zero_chk(input string tag);
      chk({tag, " out_valid"}, out_valid, 0);
      chk({tag, " in_ready"}, in_ready, 0);
      chk({tag, " out_A"}, out_A, 0);
      chk({tag, " out_B"}, out_B, 0);
      chk({tag, " out_opcode"}, out_opcode, 0);
      chk({tag, " out_twoLSB"}, out_twoLSB, 0);
      chk({tag, " out_ctrl"}, out_ctrl, 0);
      chk({tag, " out_halt"}, out_halt, 0);
   endtask

   initial begin
      //          instr     rs        rt        A         B         op     lsb   ctrl    halt
      vecs[0]  = '{16'h4A23, 16'h0005, 16'hABCD, 16'h0005, 16'h0003, 5'h09, 2'd3, 3'b101, 1'b0}; // SUBI
      vecs[1]  = '{16'hE820, 16'h8000, 16'h0001, 16'h8000, 16'h0001, 5'h1D, 2'd0, 3'b011, 1'b0}; // SLT
      vecs[2]  = '{16'hC0F0, 16'h1234, 16'hABCD, 16'h1234, 16'hFFF0, 5'h18, 2'd0, 3'b000, 1'b0}; // LBI
      vecs[3]  = '{16'h4110, 16'h1234, 16'hABCD, 16'h1234, 16'hFFF0, 5'h08, 2'd0, 3'b000, 1'b0}; // ADDI -16
      vecs[4]  = '{16'h501F, 16'h1234, 16'hABCD, 16'h1234, 16'h001F, 5'h0A, 2'd3, 3'b000, 1'b0}; // XORI
      vecs[5]  = '{16'h5815, 16'h1234, 16'hABCD, 16'h1234, 16'h0015, 5'h0B, 2'd1, 3'b010, 1'b0}; // ANDNI
      vecs[6]  = '{16'hD801, 16'h1234, 16'hABCD, 16'h1234, 16'hABCD, 5'h1B, 2'd1, 3'b101, 1'b0}; // SUB
      vecs[7]  = '{16'hD803, 16'h1234, 16'hABCD, 16'h1234, 16'hABCD, 5'h1B, 2'd3, 3'b010, 1'b0}; // ANDN
      vecs[8]  = '{16'hD800, 16'h1234, 16'hABCD, 16'h1234, 16'hABCD, 5'h1B, 2'd0, 3'b000, 1'b0}; // ADD
      vecs[9]  = '{16'h9080, 16'h1234, 16'hABCD, 16'h1234, 16'h0080, 5'h12, 2'd0, 3'b000, 1'b0}; // SLBI
      vecs[10] = '{16'h2401, 16'h1234, 16'hABCD, 16'h1234, 16'hFC01, 5'h04, 2'd1, 3'b000, 1'b0}; // J
      vecs[11] = '{16'h0800, 16'h1234, 16'hABCD, 16'h0000, 16'h0000, 5'h01, 2'd0, 3'b000, 1'b0}; // NOP
      vecs[12] = '{16'h607F, 16'h1234, 16'hABCD, 16'h1234, 16'h007F, 5'h0C, 2'd3, 3'b000, 1'b0}; // BEQZ
      vecs[13] = '{16'hE000, 16'h1234, 16'hABCD, 16'h1234, 16'hABCD, 5'h1C, 2'd0, 3'b011, 1'b0}; // SEQ
      vecs[14] = '{16'hF800, 16'h1234, 16'hABCD, 16'h1234, 16'hABCD, 5'h1F, 2'd0, 3'b000, 1'b0}; // SCO
      vecs[15] = '{16'hA010, 16'h1234, 16'hABCD, 16'h1234, 16'h0010, 5'h14, 2'd0, 3'b000, 1'b0}; // ROLI
      vecs[16] = '{16'hC8FF, 16'h1234, 16'hABCD, 16'h1234, 16'h0000, 5'h19, 2'd3, 3'b000, 1'b0}; // 11001
      vecs[17] = '{16'h801E, 16'h1234, 16'hABCD, 16'h1234, 16'hFFFE, 5'h10, 2'd2, 3'b000, 1'b0}; // ST

      rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_rs_data = '0;
      in_rt_data = '0; flush = 1'b0; out_ready = 1'b1;

      // ---- reset state
      repeat (3) @(negedge clk);
      all_zero_chk("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk("post-reset in_ready", in_ready, 1);

      // ---- decode table: each op into an empty block, presented next cycle
      for (int i = 0; i < NV; i++) begin
         in_valid = 1'b1; in_instr = vecs[i].instr;
         in_rs_data = vecs[i].rs; in_rt_data = vecs[i].rt; out_ready = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         chk($sformatf("v%0d out_valid", i), out_valid, 1);
         chk($sformatf("v%0d out_A", i), out_A, vecs[i].a);
         chk($sformatf("v%0d out_B", i), out_B, vecs[i].b);
         chk($sformatf("v%0d out_opcode", i), out_opcode, vecs[i].op);
         chk($sformatf("v%0d out_twoLSB", i), out_twoLSB, vecs[i].lsb);
         chk($sformatf("v%0d out_ctrl", i), out_ctrl, vecs[i].ctrl);
         chk($sformatf("v%0d out_halt", i), out_halt, vecs[i].halt);
         @(negedge clk);
      end
      chk("drained out_valid", out_valid, 0);

      // ---- stall with 3 offered ops, then release: order kept, no loss
      vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
      sent = 0;
      in_instr = 16'h4001; // ADDI imm 1
      for (int c = 0; c < 12; c++) begin
         in_valid   = (sent < 3);
         in_rs_data = (sent < 3) ? vals[sent] : 16'h0000;
         out_ready  = (c >= 4);
         if (c == 2 || c == 3) begin
            chk($sformatf("stall c%0d in_ready", c), in_ready, 0);
            chk($sformatf("stall c%0d out_A held", c), out_A, 16'h1111);
            chk($sformatf("stall c%0d out_valid", c), out_valid, 1);
         end
         if (out_valid && out_ready) seen.push_back(out_A);
         if (in_valid && in_ready) sent++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("stall handoff count", seen.size(), 3);
      for (int i = 0; i < 3; i++) begin
         got = (seen.size() > i) ? seen[i] : 16'hDEAD;
         chk($sformatf("stall order %0d", i), got, vals[i]);
      end

      // ---- flush wins over a same-cycle accept
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h4001; in_rs_data = 16'h7777;
      @(negedge clk);
      in_rs_data = 16'h8888; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      chk("flush out_valid", out_valid, 0);
      chk("flush in_ready", in_ready, 1);
      @(negedge clk);
      chk("flush input dropped", out_valid, 0);

      // ---- HALT then flush before hand-off
      in_valid = 1'b1; in_instr = 16'h0000; in_rs_data = 16'h5555; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      chk("halt1 out_valid", out_valid, 1);
      chk("halt1 out_halt", out_halt, 1);
      chk("halt1 out_A", out_A, 0);
      chk("halt1 in_ready", in_ready, 0);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("halt flush out_valid", out_valid, 0);
      chk("halt flush in_ready", in_ready, 1);

      // ---- HALT handed off -> halted until reset
      in_valid = 1'b1; in_instr = 16'h0000; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("halt2 out_valid", out_valid, 1);
      chk("halt2 out_halt", out_halt, 1);
      @(negedge clk);
      chk("halted out_valid", out_valid, 0);
      chk("halted in_ready", in_ready, 0);
      in_valid = 1'b1; in_instr = 16'h4001; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      repeat (3) @(negedge clk);
      chk("halted after flush in_ready", in_ready, 0);
      chk("halted after flush out_valid", out_valid, 0);
      in_valid = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      chk("halted reset in_ready", in_ready, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("halt cleared in_ready", in_ready, 1);

      // ---- reset with both entries full
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h4A23; in_rs_data = 16'h0005;
      @(negedge clk);
      in_instr = 16'hE820; in_rs_data = 16'h8000; in_rt_data = 16'h0001;
      chk("fill2 in_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("full in_ready", in_ready, 0);
      chk("full out_ctrl", out_ctrl, 3'b101);
      rst_n = 1'b0;
      @(negedge clk);
      all_zero_chk("midreset");
      rst_n = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk("midreset skid dropped", out_valid, 0);
      chk("midreset in_ready", in_ready, 1);

`ifdef ALU_ISSUE_PERF_EN
      chk("perf after reset", perf_count, 0);
      in_valid = 1'b1; in_instr = 16'h0800; out_ready = 1'b1;
      repeat (70001) @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("perf saturate", perf_count, 16'hFFFF);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("perf kept by flush", perf_count, 16'hFFFF);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
